// File: rtl/ysyx_24120009_pkg.sv
// Shared definitions for the write-back unit: write-back source select
// encodings, load funct3 encodings and the FSM state type.
package ysyx_24120009_pkg;

  // Write-back data source selected by the decoder.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_t;

  // Load funct3 encodings (RV32I).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Write-back FSM states.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_24120009_wbu_if.sv
// Bus bundle between the execute/memory stages and the write-back unit:
// upstream instruction hand-off, memory read response and the register
// file write port. The master side feeds the WBU; the slave side is the WBU.
interface ysyx_24120009_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic [1:0]            in_wb_sel;
  logic [DATA_WIDTH-1:0] in_alu_res;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_csr_rdata;
  logic [2:0]            in_funct3;
  logic [1:0]            in_addr_lo;

  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  wb_done;

  modport master (
    output in_valid, in_rd, in_rd_wen, in_wb_sel, in_alu_res, in_pc,
           in_csr_rdata, in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, wb_done
  );

  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_wb_sel, in_alu_res, in_pc,
           in_csr_rdata, in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
    output in_ready, rf_wen, rf_waddr, rf_wdata, wb_done
  );
endinterface

// File: rtl/ysyx_24120009_wbu_load_fmt.sv
// Combinational load formatter: aligns the memory word by the byte offset
// and applies the sign/zero extension selected by funct3. A halfword at
// offset 3 naturally picks up a zero upper byte from the shift.
module ysyx_24120009_load_fmt
  import ysyx_24120009_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            in_addr_lo,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic signed [7:0]     byte_s;
  logic signed [15:0]    half_s;

  // Align, then extend according to the load type.
  always_comb begin
    shifted = mem_rdata >> {in_addr_lo, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    data    = shifted;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
      F3_LH:   data = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
      F3_LW:   data = shifted;
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_24120009_wbu.sv
// Write-back unit: accepts one instruction at a time, waits for load data
// when needed, and issues a single-cycle register-file write plus a
// retirement pulse. Optional trace outputs are enabled by defining
// YSYX_24120009_WBU_TRACE_EN.
module ysyx_24120009_wbu
  import ysyx_24120009_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_24120009_wbu_if.slave bus
`ifdef YSYX_24120009_WBU_TRACE_EN
  ,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic [63:0]           commit_cnt
`endif
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;
  wb_sel_t               wb_sel_q;
  logic [DATA_WIDTH-1:0] alu_res_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] csr_rdata_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [DATA_WIDTH-1:0] load_data;

  // Selects the value written back for a given source.
  function automatic logic [DATA_WIDTH-1:0] wb_mux(
    input wb_sel_t               sel,
    input logic [DATA_WIDTH-1:0] alu,
    input logic [DATA_WIDTH-1:0] pc,
    input logic [DATA_WIDTH-1:0] csr,
    input logic [DATA_WIDTH-1:0] ld
  );
    case (sel)
      WB_ALU:  wb_mux = alu;
      WB_PC4:  wb_mux = pc + DATA_WIDTH'(4);
      WB_CSR:  wb_mux = csr;
      default: wb_mux = ld;
    endcase
  endfunction

  // Formatting uses the captured offset/type and the live response word.
  ysyx_24120009_load_fmt #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_fmt (
    .mem_rdata (bus.mem_rdata),
    .in_addr_lo(addr_lo_q),
    .funct3    (funct3_q),
    .data      (load_data)
  );

  // Only an idle unit can take a new instruction.
  assign bus.in_ready = (state == S_IDLE);

  // FSM with registered write-port outputs. Non-load instructions load the
  // write registers on the accept edge so the write is visible the next
  // cycle; loads do the same on the mem_rvalid edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rd_q         <= '0;
      rd_wen_q     <= 1'b0;
      wb_sel_q     <= WB_ALU;
      alu_res_q    <= '0;
      pc_q         <= '0;
      csr_rdata_q  <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      bus.rf_wen   <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.wb_done  <= 1'b0;
`ifdef YSYX_24120009_WBU_TRACE_EN
      commit_pc    <= '0;
      commit_cnt   <= '0;
`endif
    end else begin
      bus.rf_wen  <= 1'b0;
      bus.wb_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            rd_q        <= bus.in_rd;
            rd_wen_q    <= bus.in_rd_wen;
            wb_sel_q    <= wb_sel_t'(bus.in_wb_sel);
            alu_res_q   <= bus.in_alu_res;
            pc_q        <= bus.in_pc;
            csr_rdata_q <= bus.in_csr_rdata;
            funct3_q    <= bus.in_funct3;
            addr_lo_q   <= bus.in_addr_lo;
            if (wb_sel_t'(bus.in_wb_sel) == WB_MEM) begin
              state <= S_WAIT_MEM;
            end else begin
              state        <= S_WRITE;
              bus.rf_wen   <= bus.in_rd_wen && (bus.in_rd != '0);
              bus.rf_waddr <= bus.in_rd;
              bus.rf_wdata <= wb_mux(wb_sel_t'(bus.in_wb_sel), bus.in_alu_res,
                                     bus.in_pc, bus.in_csr_rdata, '0);
              bus.wb_done  <= 1'b1;
`ifdef YSYX_24120009_WBU_TRACE_EN
              commit_pc    <= bus.in_pc;
              commit_cnt   <= commit_cnt + 64'd1;
`endif
            end
          end
        end
        S_WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            state        <= S_WRITE;
            bus.rf_wen   <= rd_wen_q && (rd_q != '0);
            bus.rf_waddr <= rd_q;
            bus.rf_wdata <= wb_mux(wb_sel_q, alu_res_q, pc_q, csr_rdata_q,
                                   load_data);
            bus.wb_done  <= 1'b1;
`ifdef YSYX_24120009_WBU_TRACE_EN
            commit_pc    <= pc_q;
            commit_cnt   <= commit_cnt + 64'd1;
`endif
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_24120009_wbu.md
YSYX_24120009_WBU -- requirements
Module: ysyx_24120009_wbu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-003 SHALL have port clk, input, 1, the only clock; all state on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have upstream ports: in_valid (input, 1); in_ready (output, 1); in_rd (input, ADDR_WIDTH); in_rd_wen (input, 1); in_wb_sel (input, 2: 0 ALU, 1 MEM, 2 PC+4, 3 CSR); in_alu_res, in_pc, in_csr_rdata (input, DATA_WIDTH each); in_funct3 (input, 3); in_addr_lo (input, 2, load byte offset).
REQ-006 SHALL have memory-response ports mem_rvalid (input, 1) and mem_rdata (input, DATA_WIDTH, aligned word).
REQ-007 SHALL have register-file write ports rf_wen (output, 1), rf_waddr (output, ADDR_WIDTH), rf_wdata (output, DATA_WIDTH).
REQ-008 SHALL have port wb_done (output, 1), a one-cycle pulse per retired instruction.

Function
REQ-009 SHALL implement FSM IDLE, WAIT_MEM, WRITE; in_ready = 1 only in IDLE.
REQ-010 IDLE + in_valid: capture all in_* fields; next state WAIT_MEM if in_wb_sel==MEM, else WRITE.
REQ-011 WAIT_MEM: hold until mem_rvalid; at that edge capture formatted load data, go to WRITE.
REQ-012 WRITE lasts exactly one cycle: rf_wen = captured in_rd_wen AND (rd != 0); wb_done = 1; then IDLE.
REQ-013 rf_wen, rf_waddr, rf_wdata, wb_done SHALL be registered; non-load latency: accept at edge N, write visible cycle N+1, RF updated at edge N+2.
REQ-014 Write data: ALU -> in_alu_res; PC+4 -> in_pc + 4, mod 2^DATA_WIDTH; CSR -> in_csr_rdata; MEM -> formatted load.
REQ-015 Load formatting: shift mem_rdata right by 8*in_addr_lo; funct3 000 LB sign-extend byte, 001 LH sign-extend half, 010 LW full word, 100 LBU zero-extend byte, 101 LHU zero-extend half; other funct3 -> full word.
REQ-016 Misaligned half (offset 3): upper byte reads as zero before extension; no exception raised.
REQ-017 mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-018 rf_wen SHALL never assert with rf_waddr==0, even when in_rd_wen==1.
REQ-019 Outside WRITE, rf_wen=0 and wb_done=0; rf_waddr/rf_wdata hold last values.

Reset
REQ-020 On rst_n low, immediately: state IDLE; rf_wen, wb_done, rf_waddr, rf_wdata, captured fields all zero.
REQ-021 Reset in WAIT_MEM or WRITE SHALL abandon the instruction with no RF write; a mem_rvalid arriving after release SHALL be ignored.

Configuration
REQ-022 Macro YSYX_24120009_WBU_TRACE_EN defined: adds outputs commit_pc (DATA_WIDTH, captured in_pc, valid with wb_done) and commit_cnt (64, retired count, reset 0, wraps at 2^64).
REQ-023 Macro undefined: those ports and counter absent; all other behaviour identical.

Structure
REQ-024 Shared package ysyx_24120009_pkg SHALL hold wb_sel encodings, funct3 load encodings and FSM state typedef.
REQ-025 Load formatting SHALL be a combinational sub-module ysyx_24120009_load_fmt (mem_rdata, in_addr_lo, funct3 -> data).

Verification
REQ-026 ALU: in_rd=5, wen=1, alu_res=0x1234_5678 -> next cycle rf_wen=1, waddr=5, wdata=0x1234_5678, wb_done=1.
REQ-027 LB: rd=3, addr_lo=2, mem_rdata=0x0080_0000 after 3 wait cycles -> wdata=0xFFFF_FF80, in_ready=0 throughout the wait.
REQ-028 LHU: addr_lo=0, mem_rdata=0xABCD_8001 -> wdata=0x0000_8001; LH same input -> 0xFFFF_8001.
REQ-029 rd=0, wen=1, ALU 0xDEAD_BEEF -> rf_wen=0, wb_done=1.
REQ-030 JAL-type: wb_sel=PC+4, pc=0xFFFF_FFFC -> wdata=0x0000_0000.
REQ-031 rst_n low in WAIT_MEM, released, then mem_rvalid=1 -> no rf_wen, in_ready=1; with TRACE_EN, commit_cnt stays 0.
